// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
// - Default DATA_WIDTH, DEPTH and almost-full/almost-empty thresholds.
// - calc_addr_w(): pointer width derived from the depth.
// - fifo_status_t: packed snapshot of the status flags plus fill_count,
//   for benches and monitors.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AF_THRESH  = DEF_DEPTH - 4;
  localparam int DEF_AE_THRESH  = 2;

  function automatic int calc_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_ADDR_W = calc_addr_w(DEF_DEPTH);

  typedef struct packed {
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [DEF_ADDR_W:0]   fill_count;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// DATA_WIDTH x DEPTH register array with one write port and one read port.
// Ports:
// - clk: write clock.
// - wr_en, wr_addr, wr_data: synchronous write on posedge.
// - rd_addr, rd_data: asynchronous (combinational) read.
// Contents are not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO.
// Ports:
// - clk, rst: clock and asynchronous active-high reset.
// - wr_enb, wr_data: push request and data.
// - rd_enb: pop request.
// - rd_data, rd_valid: output word and qualifier.
//   FWFT=0: registered read with one-cycle latency.
//   FWFT=1: head word shown while the FIFO is not empty.
// - fill_count: number of stored words.
// - Status flags: full_flag, empty_flag, almost_full_flag, almost_empty_flag.
// - overflow_flag, underflow_flag: one-cycle pulses for rejected requests.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_enb,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_enb,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [calc_addr_w(DEPTH):0]   fill_count,
  output logic                          full_flag,
  output logic                          empty_flag,
  output logic                          almost_full_flag,
  output logic                          almost_empty_flag,
  output logic                          overflow_flag,
  output logic                          underflow_flag
);
  localparam int ADDR_W = calc_addr_w(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
  end
  if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
    $fatal(1, "sync_fifo_param: need 0 <= AE_THRESH(%0d) < AF_THRESH(%0d) <= DEPTH", AE_THRESH, AF_THRESH);
  end

  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]       count;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Accept decisions use the flags of the current cycle, so a full FIFO
  // still takes a read (and rejects the write) and an empty one takes a write.
  assign wr_acc = wr_enb && !full_flag;
  assign rd_acc = rd_enb && !empty_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overflow_flag  <= wr_enb && full_flag;
      underflow_flag <= rd_enb && empty_flag;
    end
  end

  assign fill_count        = count;
  assign full_flag         = (count == CNT_FULL);
  assign empty_flag        = (count == '0);
  assign almost_full_flag  = (count >= CNT_AF);
  assign almost_empty_flag = (count <= CNT_AE);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  if (FWFT != 0) begin : g_fwft
    // Empty output is forced to zero so stale or unwritten memory never leaks out.
    assign rd_data  = empty_flag ? '0 : head;
    assign rd_valid = !empty_flag;
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= head;
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_enb = 1'b0, rd_enb = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fill_count;
  logic       full_flag, empty_flag, almost_full_flag, almost_empty_flag;
  logic       overflow_flag, underflow_flag;

  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_wd = '0;
  logic [7:0] f_rdata;
  logic       f_rvalid;
  logic [4:0] f_cnt;
  logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data), .rd_enb(rd_enb),
    .rd_data(rd_data), .rd_valid(rd_valid), .fill_count(fill_count),
    .full_flag(full_flag), .empty_flag(empty_flag),
    .almost_full_flag(almost_full_flag), .almost_empty_flag(almost_empty_flag),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_enb(f_wr), .wr_data(f_wd), .rd_enb(f_rd),
    .rd_data(f_rdata), .rd_valid(f_rvalid), .fill_count(f_cnt),
    .full_flag(f_full), .empty_flag(f_empty),
    .almost_full_flag(f_af), .almost_empty_flag(f_ae),
    .overflow_flag(f_ov), .underflow_flag(f_un));

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    step(); step();
    nvec++; if (fill_count !== 5'd0) begin nerr++; $display("FAIL rst_count: got %0d want 0", fill_count); end
    nvec++; if ({empty_flag, almost_empty_flag} !== 2'b11) begin nerr++; $display("FAIL rst_empty_ae: got %b want 11", {empty_flag, almost_empty_flag}); end
    nvec++; if ({full_flag, almost_full_flag, overflow_flag, underflow_flag} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {full_flag, almost_full_flag, overflow_flag, underflow_flag}); end
    nvec++; if ({rd_data, rd_valid} !== 9'h0) begin nerr++; $display("FAIL rst_rd: got %h/%b want 00/0", rd_data, rd_valid); end
    nvec++; if ({f_rdata, f_rvalid, f_empty} !== 10'h001) begin nerr++; $display("FAIL rst_fwft: got %h/%b/%b want 00/0/1", f_rdata, f_rvalid, f_empty); end
    rst = 1'b0;
    wr_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin wr_data = 8'h50 + 8'(i); step(); end
    wr_enb = 1'b0;
    nvec++; if (fill_count !== 5'd5) begin nerr++; $display("FAIL load5_count: got %0d want 5", fill_count); end
    rd_enb = 1'b1; step(); rd_enb = 1'b0;
    nvec++; if ({rd_data, rd_valid} !== {8'h50, 1'b1}) begin nerr++; $display("FAIL pre_rst_read: got %h/%b want 50/1", rd_data, rd_valid); end
    nvec++; if (fill_count !== 5'd4) begin nerr++; $display("FAIL pre_rst_count: got %0d want 4", fill_count); end
    // Mid-cycle async reset: outputs must clear without waiting for an edge.
    #3 rst = 1'b1;
    #1;
    nvec++; if (fill_count !== 5'd0) begin nerr++; $display("FAIL midrst_count: got %0d want 0", fill_count); end
    nvec++; if ({empty_flag, almost_empty_flag} !== 2'b11) begin nerr++; $display("FAIL midrst_empty: got %b want 11", {empty_flag, almost_empty_flag}); end
    nvec++; if ({rd_data, rd_valid} !== 9'h0) begin nerr++; $display("FAIL midrst_rd: got %h/%b want 00/0", rd_data, rd_valid); end
    step(); rst = 1'b0;
    rd_enb = 1'b1; step(); rd_enb = 1'b0;
    nvec++; if ({underflow_flag, rd_valid, fill_count} !== {1'b1, 1'b0, 5'd0}) begin nerr++; $display("FAIL post_rst_underflow: got un=%b v=%b cnt=%0d want 1/0/0", underflow_flag, rd_valid, fill_count); end
    step();
    nvec++; if (underflow_flag !== 1'b0) begin nerr++; $display("FAIL underflow_pulse_len: got %b want 0", underflow_flag); end
  endtask

  task automatic test_fill();
    wr_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i); step();
      nvec++; if (fill_count !== 5'(i + 1)) begin nerr++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fill_count, i + 1); end
      nvec++; if (almost_full_flag !== (i + 1 >= 12)) begin nerr++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full_flag, (i + 1 >= 12)); end
      nvec++; if (full_flag !== (i + 1 == 16)) begin nerr++; $display("FAIL fill_full[%0d]: got %b want %b", i, full_flag, (i + 1 == 16)); end
    end
    wr_data = 8'hAA; step(); wr_enb = 1'b0;
    nvec++; if ({overflow_flag, fill_count} !== {1'b1, 5'd16}) begin nerr++; $display("FAIL overflow: got ov=%b cnt=%0d want 1/16", overflow_flag, fill_count); end
    step();
    nvec++; if ({overflow_flag, fill_count} !== {1'b0, 5'd16}) begin nerr++; $display("FAIL overflow_pulse_len: got ov=%b cnt=%0d want 0/16", overflow_flag, fill_count); end
  endtask

  task automatic test_drain();
    int c;
    rd_enb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      c = 15 - k;
      nvec++; if ({rd_data, rd_valid} !== {8'(k), 1'b1}) begin nerr++; $display("FAIL drain_data[%0d]: got %h/%b want %h/1", k, rd_data, rd_valid, 8'(k)); end
      nvec++; if (fill_count !== 5'(c)) begin nerr++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, fill_count, c); end
      nvec++; if ({almost_empty_flag, empty_flag} !== {(c <= 2), (c == 0)}) begin nerr++; $display("FAIL drain_flags[%0d]: got ae=%b e=%b want %b/%b", k, almost_empty_flag, empty_flag, (c <= 2), (c == 0)); end
    end
    step(); rd_enb = 1'b0;
    nvec++; if ({underflow_flag, rd_valid, rd_data} !== {1'b1, 1'b0, 8'h0F}) begin nerr++; $display("FAIL drain_underflow: got un=%b v=%b d=%h want 1/0/0f", underflow_flag, rd_valid, rd_data); end
  endtask

  task automatic test_simul();
    wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'h77; step();
    wr_enb = 1'b0; rd_enb = 1'b0;
    nvec++; if ({fill_count, underflow_flag, rd_valid} !== {5'd1, 1'b1, 1'b0}) begin nerr++; $display("FAIL simul_empty: got cnt=%0d un=%b v=%b want 1/1/0", fill_count, underflow_flag, rd_valid); end
    rd_enb = 1'b1; step(); rd_enb = 1'b0;
    nvec++; if ({rd_data, rd_valid, fill_count} !== {8'h77, 1'b1, 5'd0}) begin nerr++; $display("FAIL simul_empty_read: got %h/%b cnt=%0d want 77/1/0", rd_data, rd_valid, fill_count); end
    wr_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin wr_data = 8'h10 + 8'(i); step(); end
    rd_enb = 1'b1; wr_data = 8'h15; step(); rd_enb = 1'b0;
    nvec++; if ({fill_count, rd_data, rd_valid} !== {5'd5, 8'h10, 1'b1}) begin nerr++; $display("FAIL simul_mid: got cnt=%0d d=%h v=%b want 5/10/1", fill_count, rd_data, rd_valid); end
    for (int i = 0; i < 11; i++) begin wr_data = 8'h16 + 8'(i); step(); end
    wr_enb = 1'b0;
    nvec++; if ({fill_count, full_flag} !== {5'd16, 1'b1}) begin nerr++; $display("FAIL simul_fill: got cnt=%0d full=%b want 16/1", fill_count, full_flag); end
    wr_enb = 1'b1; rd_enb = 1'b1; wr_data = 8'h99; step(); wr_enb = 1'b0;
    nvec++; if ({fill_count, overflow_flag, rd_data} !== {5'd15, 1'b1, 8'h11}) begin nerr++; $display("FAIL simul_full: got cnt=%0d ov=%b d=%h want 15/1/11", fill_count, overflow_flag, rd_data); end
    for (int i = 0; i < 15; i++) begin
      step();
      nvec++; if ({rd_data, rd_valid} !== {8'h12 + 8'(i), 1'b1}) begin nerr++; $display("FAIL simul_drain[%0d]: got %h/%b want %h/1", i, rd_data, rd_valid, 8'h12 + 8'(i)); end
    end
    rd_enb = 1'b0;
    nvec++; if (empty_flag !== 1'b1) begin nerr++; $display("FAIL simul_end_empty: got %b want 1", empty_flag); end
  endtask

  task automatic test_wrap();
    int wi = 0, ri = 0, cnt = 0, cyc = 0;
    bit up = 1'b1, w, r;
    while (ri < 40 && cyc < 300) begin
      if (cnt >= 10) up = 1'b0;
      else if (cnt <= 3) up = 1'b1;
      w = (wi < 40) && (up || (cyc % 3 == 0));
      r = (cnt > 0) && (!up || (cyc % 3 == 0) || wi >= 40);
      wr_enb = w; rd_enb = r; wr_data = 8'(wi);
      step();
      if (w) wi++;
      if (r) begin
        nvec++; if ({rd_data, rd_valid} !== {8'(ri), 1'b1}) begin nerr++; $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", ri, rd_data, rd_valid, 8'(ri)); end
        ri++;
      end
      cnt = cnt + int'(w) - int'(r);
      nvec++; if (fill_count !== 5'(cnt)) begin nerr++; $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, fill_count, cnt); end
      nvec++; if ({empty_flag, almost_empty_flag, almost_full_flag, full_flag} !== {(cnt == 0), (cnt <= 2), (cnt >= 12), (cnt == 16)}) begin
        nerr++; $display("FAIL wrap_flags[%0d]: got %b for count %0d", cyc, {empty_flag, almost_empty_flag, almost_full_flag, full_flag}, cnt);
      end
      cyc++;
    end
    wr_enb = 1'b0; rd_enb = 1'b0;
    nvec++; if (ri != 40) begin nerr++; $display("FAIL wrap_timeout: read %0d words want 40", ri); end
  endtask

  task automatic test_fwft();
    f_wr = 1'b1; f_wd = 8'h3C; step();
    f_wd = 8'h5A; step(); f_wr = 1'b0;
    nvec++; if ({f_rdata, f_rvalid, f_cnt} !== {8'h3C, 1'b1, 5'd2}) begin nerr++; $display("FAIL fwft_head: got %h/%b cnt=%0d want 3c/1/2", f_rdata, f_rvalid, f_cnt); end
    f_rd = 1'b1; step(); f_rd = 1'b0;
    nvec++; if ({f_rdata, f_rvalid} !== {8'h5A, 1'b1}) begin nerr++; $display("FAIL fwft_pop1: got %h/%b want 5a/1", f_rdata, f_rvalid); end
    f_rd = 1'b1; step(); f_rd = 1'b0;
    nvec++; if ({f_empty, f_rvalid} !== 2'b10) begin nerr++; $display("FAIL fwft_pop2: got e=%b v=%b want 1/0", f_empty, f_rvalid); end
    f_wr = 1'b1; f_wd = 8'h3C; step(); f_wr = 1'b0;
    nvec++; if ({f_rdata, f_rvalid} !== {8'h3C, 1'b1}) begin nerr++; $display("FAIL fwft_latency: got %h/%b want 3c/1", f_rdata, f_rvalid); end
    f_rd = 1'b1; step(); f_rd = 1'b0;
    nvec++; if ({f_empty, f_rvalid, f_un} !== 3'b100) begin nerr++; $display("FAIL fwft_pop3: got e=%b v=%b un=%b want 1/0/0", f_empty, f_rvalid, f_un); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_wrap();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
